// File: rtl/tt_sweep_ctrl_if.sv
// Start/done control and function-under-test bundle for tt_sweep_ctrl.
// Optional macro TT_ABORT_EN adds the abort request signal.
interface tt_sweep_ctrl_if #(
  parameter int N_IN = 4
);
  localparam int NV = 1 << N_IN;

  logic              start;
  logic [NV-1:0]     expected;
  logic              f_in;
`ifdef TT_ABORT_EN
  logic              abort;
`endif
  logic [N_IN-1:0]   vec;
  logic              busy;
  logic              done;
  logic [NV-1:0]     truth_table;
  logic [N_IN:0]     err_count;
  logic              pass;
  logic [N_IN-1:0]   first_err;

  // Host side: issues start, supplies the expected mask and the function output.
  modport master (
`ifdef TT_ABORT_EN
    output abort,
`endif
    output start, expected, f_in,
    input  vec, busy, done, truth_table, err_count, pass, first_err
  );

  // Sequencer side.
  modport slave (
`ifdef TT_ABORT_EN
    input  abort,
`endif
    input  start, expected, f_in,
    output vec, busy, done, truth_table, err_count, pass, first_err
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweep of a combinational function with a self-check
// against an expected minterm mask. Optional macro TT_ABORT_EN adds abort.
module tt_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  tt_sweep_ctrl_if.slave sw
);
  localparam int NV = 1 << N_IN;
  localparam int EW = N_IN + 1;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  // NEXT is folded into the sample edge, so the FSM never rests there.
  typedef enum logic [1:0] {IDLE, HOLD, NEXT, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic [N_IN-1:0] vec_q;
  logic [NV-1:0]   tt_q;
  logic [EW-1:0]   err_q;
  logic [EW-1:0]   err_inc;
  logic [N_IN-1:0] first_err_q;
  logic            pass_q;
  logic            abort_hit;
  logic            sample;
  logic            last_vec;
  logic            mism;
  logic            busy_c;
  logic            done_c;

  always_comb begin
    abort_hit = 1'b0;
`ifdef TT_ABORT_EN
    abort_hit = sw.abort;
`endif
    sample   = (state_q == HOLD) && (cnt_q == 4'd0) && !abort_hit;
    last_vec = &vec_q;
    mism     = (sw.f_in != sw.expected[vec_q]);
    err_inc  = err_q + EW'(mism);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sw.start) state_d = HOLD;
      HOLD: begin
        if (abort_hit)               state_d = IDLE;
        else if (sample && last_vec) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state_q == HOLD);
    done_c = (state_q == DONE);
  end

  // Datapath: vector/hold counters and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q       <= '0;
      cnt_q       <= '0;
      tt_q        <= '0;
      err_q       <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else if (state_q == IDLE && sw.start) begin
      vec_q       <= '0;
      cnt_q       <= SETTLE_C;
      tt_q        <= '0;
      err_q       <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else if (state_q == HOLD && !abort_hit) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        tt_q[vec_q] <= sw.f_in;
        err_q       <= err_inc;
        if (mism && err_q == '0) first_err_q <= vec_q;
        // pass uses the count including the final vector's result.
        if (last_vec) begin
          pass_q <= (err_inc == '0);
        end else begin
          vec_q <= vec_q + 1'b1;
          cnt_q <= SETTLE_C;
        end
      end
    end
  end

  assign sw.vec         = vec_q;
  assign sw.busy        = busy_c;
  assign sw.done        = done_c;
  assign sw.truth_table = tt_q;
  assign sw.err_count   = err_q;
  assign sw.pass        = pass_q;
  assign sw.first_err   = first_err_q;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl driving a 4-input PoS model (zeros at
// 0,1,6,7,8,9,12,14); second instance uses SETTLE=3.
module tb_tt_sweep_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  tt_sweep_ctrl_if #(.N_IN(4)) if0 ();
  tt_sweep_ctrl_if #(.N_IN(4)) if1 ();

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_dut0 (.clk(clk), .reset(reset), .sw(if0.slave));
  tt_sweep_ctrl #(.N_IN(4), .SETTLE(3)) u_dut1 (.clk(clk), .reset(reset), .sw(if1.slave));

  function automatic logic pos_model(input logic [3:0] v);
    case (v)
      4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd14: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign if0.f_in = pos_model(if0.vec);
  assign if1.f_in = pos_model(if1.vec);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Pulse start on one instance and watch ncyc cycles after the start edge.
  task automatic run_sweep(input bit sel, input logic [15:0] exp_tt, input int ncyc,
                           input bit repulse, input int ca, input int cb,
                           output int done_cyc, output int n_done,
                           output int busy_first, output int busy_last,
                           output int vec_a, output int vec_b);
    logic d_done, d_busy;
    logic [3:0] d_vec;
    done_cyc = -1; n_done = 0; busy_first = -1; busy_last = -1; vec_a = -1; vec_b = -1;
    @(negedge clk);
    if (sel) begin if1.expected = exp_tt; if1.start = 1'b1; end
    else     begin if0.expected = exp_tt; if0.start = 1'b1; end
    @(posedge clk);
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (sel) if1.start = 1'b0;
      else     if0.start = repulse && (cyc == 5 || cyc == 20);
      d_done = sel ? if1.done : if0.done;
      d_busy = sel ? if1.busy : if0.busy;
      d_vec  = sel ? if1.vec  : if0.vec;
      if (d_done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
      if (d_busy) begin if (busy_first < 0) busy_first = cyc; busy_last = cyc; end
      if (cyc == ca) vec_a = int'(d_vec);
      if (cyc == cb) vec_b = int'(d_vec);
    end
    if0.start = 1'b0;
  endtask

  initial begin
    int dc, nd, bf, bl, va, vb;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    if0.start = 1'b0; if0.expected = '0;
    if1.start = 1'b0; if1.expected = '0;
`ifdef TT_ABORT_EN
    if0.abort = 1'b0;
    if1.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  32'(if0.busy), 32'd0);
    check_eq("rst_done",  32'(if0.done), 32'd0);
    check_eq("rst_vec",   32'(if0.vec), 32'd0);
    check_eq("rst_table", 32'(if0.truth_table), 32'd0);
    check_eq("rst_err",   32'(if0.err_count), 32'd0);
    check_eq("rst_pass",  32'(if0.pass), 32'd0);
    check_eq("rst_ferr",  32'(if0.first_err), 32'd0);
    reset = 1'b0;

    // Matching mask.
    run_sweep(1'b0, 16'hAC3C, 40, 1'b0, 13, 15, dc, nd, bf, bl, va, vb);
    check_eq("s1_done_cyc", 32'(dc), 32'd33);
    check_eq("s1_n_done",   32'(nd), 32'd1);
    check_eq("s1_busy_1st", 32'(bf), 32'd1);
    check_eq("s1_busy_lst", 32'(bl), 32'd32);
    check_eq("s1_vec_c13",  32'(va), 32'd6);
    check_eq("s1_vec_c15",  32'(vb), 32'd7);
    check_eq("s1_table",    32'(if0.truth_table), 32'hAC3C);
    check_eq("s1_err",      32'(if0.err_count), 32'd0);
    check_eq("s1_pass",     32'(if0.pass), 32'd1);
    check_eq("s1_ferr",     32'(if0.first_err), 32'd0);

    // Single mismatch at vector 6.
    run_sweep(1'b0, 16'hAC7C, 40, 1'b0, 0, 0, dc, nd, bf, bl, va, vb);
    check_eq("s2_done_cyc", 32'(dc), 32'd33);
    check_eq("s2_table",    32'(if0.truth_table), 32'hAC3C);
    check_eq("s2_err",      32'(if0.err_count), 32'd1);
    check_eq("s2_pass",     32'(if0.pass), 32'd0);
    check_eq("s2_ferr",     32'(if0.first_err), 32'd6);

    // Every vector mismatches: count reaches 16 without wrapping.
    run_sweep(1'b0, 16'h53C3, 40, 1'b0, 0, 0, dc, nd, bf, bl, va, vb);
    check_eq("s3_err",   32'(if0.err_count), 32'd16);
    check_eq("s3_ferr",  32'(if0.first_err), 32'd0);
    check_eq("s3_pass",  32'(if0.pass), 32'd0);
    check_eq("s3_table", 32'(if0.truth_table), 32'hAC3C);

    // SETTLE=3: four cycles per vector.
    run_sweep(1'b1, 16'hAC3C, 72, 1'b0, 12, 13, dc, nd, bf, bl, va, vb);
    check_eq("s4_done_cyc", 32'(dc), 32'd65);
    check_eq("s4_n_done",   32'(nd), 32'd1);
    check_eq("s4_busy_lst", 32'(bl), 32'd64);
    check_eq("s4_vec_c12",  32'(va), 32'd2);
    check_eq("s4_vec_c13",  32'(vb), 32'd3);
    check_eq("s4_table",    32'(if1.truth_table), 32'hAC3C);
    check_eq("s4_err",      32'(if1.err_count), 32'd0);
    check_eq("s4_pass",     32'(if1.pass), 32'd1);

    // start re-pulsed mid-sweep is ignored.
    run_sweep(1'b0, 16'hAC3C, 40, 1'b1, 0, 0, dc, nd, bf, bl, va, vb);
    check_eq("s5_n_done",   32'(nd), 32'd1);
    check_eq("s5_done_cyc", 32'(dc), 32'd33);
    check_eq("s5_pass",     32'(if0.pass), 32'd1);

    // Reset in cycle 10 of a sweep.
    nd = 0;
    @(negedge clk);
    if0.expected = 16'hAC3C; if0.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if (if0.done) nd++;
      if (cyc == 10) begin
        check_eq("s6_table_pre", 32'(if0.truth_table), 32'h000C);
        reset = 1'b1;
      end
      if (cyc == 11) begin
        check_eq("s6_busy",  32'(if0.busy), 32'd0);
        check_eq("s6_vec",   32'(if0.vec), 32'd0);
        check_eq("s6_table", 32'(if0.truth_table), 32'd0);
        check_eq("s6_err",   32'(if0.err_count), 32'd0);
        reset = 1'b0;
      end
    end
    check_eq("s6_n_done", 32'(nd), 32'd0);
    run_sweep(1'b0, 16'hAC3C, 40, 1'b0, 0, 0, dc, nd, bf, bl, va, vb);
    check_eq("s6_re_done",  32'(dc), 32'd33);
    check_eq("s6_re_table", 32'(if0.truth_table), 32'hAC3C);
    check_eq("s6_re_pass",  32'(if0.pass), 32'd1);

`ifdef TT_ABORT_EN
    // Abort in cycle 12: vectors 0..4 captured, vector 5 sample suppressed.
    nd = 0;
    @(negedge clk);
    if0.expected = 16'hAC3C; if0.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if (if0.done) nd++;
      if (cyc == 12) if0.abort = 1'b1;
      if (cyc == 13) begin
        if0.abort = 1'b0;
        check_eq("s7_busy", 32'(if0.busy), 32'd0);
      end
    end
    check_eq("s7_n_done", 32'(nd), 32'd0);
    check_eq("s7_pass",   32'(if0.pass), 32'd0);
    check_eq("s7_table",  32'(if0.truth_table), 32'h001C);
    check_eq("s7_err",    32'(if0.err_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
